// File: rtl/sqrt_pkg.sv
// Shared types and widths for the sqrt arbiter slice.
package sqrt_pkg;

  localparam int unsigned OP_W  = 16;
  localparam int unsigned RES_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/sqrt_arbiter_if.sv
// Requester bus plus sqrt-core handshake shared by the arbiter and its parent.
interface sqrt_arbiter_if
  import sqrt_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) ();

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*OP_W-1:0] req_data;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ-1:0]      rsp_valid;
  logic [RES_W-1:0]        rsp_data;
  logic                    rsp_err;
  logic                    sqrt_start;
  logic [OP_W-1:0]         sqrt_data_in;
  logic [RES_W-1:0]        sqrt_data_out;
  logic                    sqrt_done;
  logic                    busy;

  // Arbiter side
  modport slave (
    input  req_valid, req_data, sqrt_data_out, sqrt_done,
    output req_ready, rsp_valid, rsp_data, rsp_err, sqrt_start, sqrt_data_in, busy
  );

  // Requesters and sqrt core side
  modport master (
    output req_valid, req_data, sqrt_data_out, sqrt_done,
    input  req_ready, rsp_valid, rsp_data, rsp_err, sqrt_start, sqrt_data_in, busy
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin winner: first request strictly above last_i, else wrap from 0.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic found;

  // Two ascending passes avoid modulo arithmetic on the index.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!found && req_i[j] && (IDX_W'(j) > last_i)) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
      end
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!found && req_i[j] && (IDX_W'(j) <= last_i)) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/sqrt_arbiter.sv
// Shares one external sqrt core among NUM_REQ requesters, one operation in flight.
module sqrt_arbiter
  import sqrt_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  sqrt_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sqrt_start_q, sqrt_start_d;
  logic [OP_W-1:0]    sqrt_data_in_q, sqrt_data_in_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [RES_W-1:0]   rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic [OP_W-1:0]    pick_op;
  logic               accept;
  logic               done_qual;
  logic               timeout;

  // grant_q doubles as last_grant: both change only on accept.
  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i  (bus.req_valid),
    .last_i (grant_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx)
  );

  // Ready must react to req_valid within the cycle, so it is decoded from state.
  assign bus.req_ready = (state_q == ST_IDLE) ? pick_gnt : '0;
  assign accept        = |(bus.req_valid & bus.req_ready);
  assign done_qual     = (cnt_q != '0) && bus.sqrt_done;
  assign timeout       = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Operand of the current round-robin winner.
  always_comb begin
    pick_op = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) pick_op = bus.req_data[i*OP_W +: OP_W];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    cnt_d          = cnt_q;
    sqrt_start_d   = 1'b0;
    sqrt_data_in_d = sqrt_data_in_q;
    rsp_valid_d    = '0;
    rsp_data_d     = rsp_data_q;
    rsp_err_d      = rsp_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d        = ST_ISSUE;
          grant_d        = pick_idx;
          sqrt_start_d   = 1'b1;
          sqrt_data_in_d = pick_op;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        // The first WAIT cycle (cnt_q == 0) ignores a done level left over from before.
        if (done_qual) begin
          state_d     = ST_RESP;
          rsp_valid_d = NUM_REQ'(1) << grant_q;
          rsp_data_d  = bus.sqrt_data_out;
          rsp_err_d   = 1'b0;
        end else if (timeout) begin
          state_d     = ST_RESP;
          rsp_valid_d = NUM_REQ'(1) << grant_q;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      grant_q        <= IDX_W'(NUM_REQ - 1);
      cnt_q          <= '0;
      sqrt_start_q   <= 1'b0;
      sqrt_data_in_q <= '0;
      rsp_valid_q    <= '0;
      rsp_data_q     <= '0;
      rsp_err_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      cnt_q          <= cnt_d;
      sqrt_start_q   <= sqrt_start_d;
      sqrt_data_in_q <= sqrt_data_in_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      rsp_err_q      <= rsp_err_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.sqrt_start   = sqrt_start_q;
  assign bus.sqrt_data_in = sqrt_data_in_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Self-checking bench: behavioural sqrt core, transaction-level arbiter model, random traffic.
module tb_sqrt_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int TIMEOUT_CYC = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  sqrt_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  sqrt_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [7:0] isqrt(input logic [15:0] x);
    logic [7:0] r;
    r = 8'd0;
    for (int i = 0; i < 256; i++) if (i * i <= int'(x)) r = 8'(i);
    return r;
  endfunction

  // Sqrt core: done rises core_lat edges after it samples start. With core_hold the
  // done level stays high until one edge after the next start is sampled.
  int          core_lat  = 4;
  bit          core_off  = 1'b0;
  bit          core_hold = 1'b0;
  int          core_cnt  = 0;
  logic [15:0] core_op   = '0;
  logic        core_done = 1'b0;
  logic [7:0]  core_res  = '0;
  logic        stale_clr = 1'b0;

  assign bus.sqrt_done     = core_done;
  assign bus.sqrt_data_out = core_res;

  always @(posedge clk) begin
    stale_clr <= bus.sqrt_start;
    if (bus.sqrt_start && !core_off) begin
      core_cnt <= core_lat;
      core_op  <= bus.sqrt_data_in;
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt - 1;
    end
    if (core_cnt == 1 && !bus.sqrt_start) begin
      core_done <= 1'b1;
      core_res  <= isqrt(core_op);
    end else if (!core_hold || stale_clr) begin
      core_done <= 1'b0;
    end
  end

  // Transaction model: one operation in flight; response due core_lat+2 edges after the
  // start is sampled, or TIMEOUT_CYC+1 edges after it when the core stays silent.
  bit          in_flight  = 1'b0;
  int          m_last     = NUM_REQ - 1;
  int          m_idx      = 0;
  logic [15:0] m_op       = '0;
  logic [7:0]  m_rsp_data = '0;
  logic        m_rsp_err  = 1'b0;
  bit          m_err_exp  = 1'b0;
  int          acc_cyc    = -10;
  int          due        = -10;
  int          win;
  int          wj;
  logic [3:0]  exp_ready;
  int          log_idx[$];
  int          log_data[$];
  int          log_err[$];

  initial forever begin
    @(negedge clk or negedge rst_n);
    if (!rst_n) begin
      in_flight  = 1'b0;
      m_last     = NUM_REQ - 1;
      m_op       = '0;
      m_rsp_data = '0;
      m_rsp_err  = 1'b0;
      acc_cyc    = -10;
      due        = -10;
    end else begin
      win = -1;
      if (!in_flight) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          wj = (m_last + k) % NUM_REQ;
          if (win < 0 && ((bus.req_valid >> wj) & 4'b1) != 4'b0) win = wj;
        end
      end
      exp_ready = (win >= 0) ? 4'(4'b1 << win) : 4'b0;
      check_eq("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      check_eq("busy", 32'(bus.busy), 32'(in_flight));
      check_eq("sqrt_start", 32'(bus.sqrt_start), 32'(in_flight && cyc == acc_cyc));
      check_eq("sqrt_data_in", 32'(bus.sqrt_data_in), 32'(m_op));
      if (in_flight && cyc == acc_cyc) begin
        m_err_exp = core_off;
        due = core_off ? cyc + TIMEOUT_CYC + 1 : cyc + core_lat + 2;
      end
      if (in_flight && cyc == due) begin
        m_rsp_err  = m_err_exp;
        m_rsp_data = m_err_exp ? 8'd0 : isqrt(m_op);
        check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(4'(4'b1 << m_idx)));
        log_idx.push_back(m_idx);
        log_data.push_back(int'(bus.rsp_data));
        log_err.push_back(int'(bus.rsp_err));
        in_flight = 1'b0;
      end else begin
        check_eq("rsp_valid_quiet", 32'(bus.rsp_valid), 32'd0);
      end
      check_eq("rsp_data", 32'(bus.rsp_data), 32'(m_rsp_data));
      check_eq("rsp_err", 32'(bus.rsp_err), 32'(m_rsp_err));
      if (win >= 0) begin
        in_flight = 1'b1;
        m_idx     = win;
        m_last    = win;
        m_op      = 16'(bus.req_data >> (16 * win));
        acc_cyc   = cyc + 1;
        due       = -10;
      end
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    while (in_flight && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq("drain", 32'(in_flight), 32'd0);
  endtask

  // Hold each requester in mask valid until it is accepted, then let the block drain.
  task automatic do_req(input logic [3:0] mask, input logic [63:0] data);
    logic [3:0] pend;
    int t;
    pend          = mask;
    t             = 0;
    bus.req_data  = data;
    bus.req_valid = pend;
    while (pend != 4'b0 && t < 500) begin
      @(negedge clk);
      pend = pend & ~(bus.req_valid & bus.req_ready);
      @(posedge clk); #1;
      bus.req_valid = pend;
      t++;
    end
    check_eq("req_served", 32'(pend), 32'd0);
    wait_idle();
  endtask

  task automatic check_log(input string tag, input int n, input int e_idx[4],
                           input int e_data[4], input int e_err[4]);
    check_eq({tag, "_count"}, 32'(log_idx.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < log_idx.size()) begin
        check_eq({tag, "_idx"}, 32'(log_idx[i]), 32'(e_idx[i]));
        check_eq({tag, "_data"}, 32'(log_data[i]), 32'(e_data[i]));
        check_eq({tag, "_err"}, 32'(log_err[i]), 32'(e_err[i]));
      end
    end
  endtask

  task automatic clear_log();
    log_idx.delete();
    log_data.delete();
    log_err.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [63:0] d;
    bus.req_valid = '0;
    bus.req_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    check_eq("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check_eq("rst_sqrt_start", 32'(bus.sqrt_start), 32'd0);
    check_eq("rst_sqrt_data_in", 32'(bus.sqrt_data_in), 32'd0);
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // All four valid from reset: grant order 0,1,2,3
    clear_log();
    core_lat = 3;
    do_req(4'b1111, {16'd256, 16'd65535, 16'd1, 16'd0});
    check_log("order", 4, '{0, 1, 2, 3}, '{0, 1, 255, 16}, '{0, 0, 0, 0});

    // Last grant was 3: requester 0 wins over 3
    clear_log();
    core_lat = 2;
    do_req(4'b1001, {16'd9, 16'd0, 16'd0, 16'd25});
    check_log("wrap", 2, '{0, 3, 0, 0}, '{5, 3, 0, 0}, '{0, 0, 0, 0});

    // Single request, slow core
    clear_log();
    core_lat = 17;
    do_req(4'b0001, 64'd144);
    check_log("single", 1, '{0, 0, 0, 0}, '{12, 0, 0, 0}, '{0, 0, 0, 0});

    // Done level held over into the next operation
    clear_log();
    core_lat  = 5;
    core_hold = 1'b1;
    do_req(4'b0010, 64'd100 << 16);
    do_req(4'b0010, 64'd49 << 16);
    core_hold = 1'b0;
    check_log("stale", 2, '{1, 1, 0, 0}, '{10, 7, 0, 0}, '{0, 0, 0, 0});

    // Core never completes
    clear_log();
    core_off = 1'b1;
    do_req(4'b0100, 64'd400 << 32);
    core_off = 1'b0;
    check_log("timeout", 1, '{2, 0, 0, 0}, '{0, 0, 0, 0}, '{1, 0, 0, 0});
    check_eq("timeout_idle", 32'(bus.busy), 32'd0);

    // Reset while waiting on the core
    clear_log();
    core_lat      = 10;
    bus.req_data  = 64'd81 << 32;
    bus.req_valid = 4'b0100;
    t = 0;
    while (!in_flight && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    bus.req_valid = '0;
    check_eq("rst_accept", 32'(in_flight), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", 32'(bus.busy), 32'd0);
    check_eq("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("midrst_sqrt_data_in", 32'(bus.sqrt_data_in), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_eq("midrst_no_rsp", 32'(log_idx.size()), 32'd0);
    core_lat = 4;
    do_req(4'b1111, {16'd16, 16'd4, 16'd1, 16'd36});
    check_log("after_rst", 4, '{0, 1, 2, 3}, '{6, 1, 2, 4}, '{0, 0, 0, 0});

    // Random traffic, including requests dropped before acceptance
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        t = $urandom_range(0, 9);
        d[16*i +: 16] = (t == 0) ? 16'd0 : (t == 1) ? 16'hffff : 16'($urandom);
      end
      bus.req_data  = d;
      bus.req_valid = 4'($urandom) & 4'($urandom);
      core_lat      = $urandom_range(1, 15);
      @(posedge clk); #1;
    end
    bus.req_valid = '0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sqrt_arbiter.md
SQRT_ARBITER -- requirements
Module: sqrt_arbiter

Interface
REQ-001 The block SHALL have a parameter NUM_REQ, default 4, giving the number of requesters sharing one sqrt core (range 2..8).
REQ-002 The block SHALL have a parameter TIMEOUT_CYC, default 64, giving the maximum cycles to wait for sqrt_done.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock for all state.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port req_valid, input, NUM_REQ bits: per-requester operand valid.
REQ-006 The block SHALL have port req_data, input, NUM_REQ*16 bits: packed 16-bit operands, requester i at bits [16i+15:16i].
REQ-007 The block SHALL have port req_ready, output, NUM_REQ bits: per-requester accept, at most one bit high.
REQ-008 The block SHALL have port rsp_valid, output, NUM_REQ bits: one-hot one-cycle result strobe.
REQ-009 The block SHALL have port rsp_data, output, 8 bits: shared result bus.
REQ-010 The block SHALL have port rsp_err, output, 1 bit: qualifies rsp_valid; high means timeout, and rsp_data is then 0.
REQ-011 The block SHALL have port sqrt_start, output, 1 bit: start pulse to the sqrt core.
REQ-012 The block SHALL have port sqrt_data_in, output, 16 bits: operand to the sqrt core.
REQ-013 The block SHALL have port sqrt_data_out, input, 8 bits: result from the sqrt core.
REQ-014 The block SHALL have port sqrt_done, input, 1 bit: completion from the sqrt core.
REQ-015 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have four states, IDLE, ISSUE, WAIT and RESP, with transitions as follows.
- IDLE->ISSUE on any accept.
- ISSUE->WAIT unconditionally.
- WAIT->RESP on qualified done or on timeout.
- RESP->IDLE unconditionally.
REQ-017 In IDLE, req_ready SHALL be one-hot on the round-robin winner among asserted req_valid bits; req_ready SHALL be all-zero in every other state.
REQ-018 Round-robin SHALL search upward from (last_grant+1) mod NUM_REQ, wrapping around; last_grant updates only on an accept.
REQ-019 On accept (valid&&ready at edge T), the block SHALL register the operand and grant index; sqrt_start SHALL be high for exactly the ISSUE cycle (T+1), with sqrt_data_in holding the operand from T+1 until the next accept.
REQ-020 WAIT SHALL ignore sqrt_done during its first cycle (this tolerates a done level held over from the previous operation); from the second WAIT cycle on, sqrt_done high SHALL latch sqrt_data_out and move to RESP.
REQ-021 A saturating wait counter SHALL clear on entry to WAIT; if it reaches TIMEOUT_CYC without a qualified done, the block SHALL enter RESP with rsp_err=1 and rsp_data=0.
REQ-022 In RESP, rsp_valid[grant] SHALL be high for exactly one cycle; rsp_data and rsp_err SHALL hold their values until the next RESP.
REQ-023 Minimum latency from accept edge to the rsp_valid cycle SHALL be (sqrt core cycles) + 3; one operation is outstanding at most.
REQ-024 req_valid dropping while the block is not in IDLE SHALL have no effect; a request dropped in IDLE before accept SHALL be lost without side effects.
REQ-025 sqrt_done arriving in IDLE, ISSUE or RESP SHALL be ignored.

Reset
REQ-026 On rst_n low, asynchronously: state=IDLE, last_grant=NUM_REQ-1 (requester 0 wins first), counter=0, sqrt_start=0, sqrt_data_in=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0.
REQ-027 Reset mid-operation SHALL abandon the in-flight result without producing any rsp_valid; the first request after deassertion SHALL restart from requester 0 priority.

Structure
REQ-028 The FSM state encoding, the 16-bit operand width and the 8-bit result width SHALL be defined in the shared package sqrt_pkg.
REQ-029 The round-robin winner logic SHALL be a sub-module rr_pick (NUM_REQ request vector plus last index in, one-hot grant plus index out, combinational).
REQ-030 The sqrt core SHALL remain outside this block, wired at the parent level.

Verification
REQ-031 Single request: req0=16'd144, core done 17 cycles after start -> sqrt_start one pulse, rsp_valid=4'b0001, rsp_data=12, rsp_err=0.
REQ-032 All four requesting with operands 0, 1, 65535 and 256 held -> grant order 0,1,2,3, results 0, 1, 255 and 16 on the matching rsp_valid bits.
REQ-033 Wrap-around: after a grant to requester 3, requesters 0 and 3 both valid -> requester 0 granted next.
REQ-034 Stale done: sqrt_done held high into the next operation -> the first WAIT cycle is ignored and no early response occurs.
REQ-035 Core never asserts done, TIMEOUT_CYC=64 -> rsp_valid with rsp_err=1 and rsp_data=0 exactly 64 WAIT cycles later, then the block returns to IDLE.
REQ-036 rst_n pulsed low in WAIT -> no rsp_valid, busy=0 immediately, and the next grant goes to requester 0.
